// File: rtl/tcp_stream_mux_if.sv
// Channel-source and TCP-transmit signal bundle for tcp_stream_mux.
// The slave modport is the mux's view; the master modport drives the sources
// and the transmitter backpressure.
interface tcp_stream_mux_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]    CH_EMPTY;
    logic [32*CHANNELS-1:0] CH_DATA;
    logic [CHANNELS-1:0]    CH_READ;
    logic                   TX_AFULL;
    logic                   TX_WR;
    logic [7:0]             TX_DATA;

    modport master (
        output CH_EMPTY, CH_DATA, TX_AFULL,
        input  CH_READ, TX_WR, TX_DATA
    );

    modport slave (
        input  CH_EMPTY, CH_DATA, TX_AFULL,
        output CH_READ, TX_WR, TX_DATA
    );
endinterface

// File: rtl/tcp_stream_mux.sv
// Round-robin multiplexer of 32-bit FWFT channel sources into one FIFO,
// followed by a byte serializer feeding a TCP transmitter.
// Each FIFO entry carries {channel index, data word}; the serializer emits an
// optional header byte and then the word LSB first.
module tcp_stream_mux #(
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 4096,
    parameter bit HEADER_EN = 1'b0
) (
    input  logic                BUS_CLK,
    input  logic                RSTn,
    tcp_stream_mux_if.slave     bus,
    output logic                FIFO_FULL,
    output logic                FIFO_EMPTY,
    output logic [15:0]         WORD_CNT
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [3:0]     NCH     = 4'(CHANNELS);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_B0, S_B1, S_B2, S_B3} state_e;

    localparam state_e FIRST_ST = HEADER_EN ? S_HDR : S_B0;

    // ---------------- arbitration ----------------
    logic [CHANNELS-1:0] req;
    logic [7:0]          req8;
    logic [255:0]        data_pad;
    logic [2:0]          ptr_q, ptr_d;
    logic [3:0]          rr_idx, nxt_idx;
    logic                gnt_vld;
    logic [2:0]          gnt_idx;
    logic [7:0]          gnt_oh;
    logic                full_w;

    // ---------------- FIFO ----------------
    logic [34:0]         mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q, cnt_d;
    logic                wr_en, pop;
    logic [34:0]         rd_word;
    logic [15:0]         wcnt_q;

    // ---------------- serializer ----------------
    state_e              state_q, state_d;
    logic [31:0]         word_q;
    logic [2:0]          ch_q;
    logic                tx_wr;
    logic [7:0]          tx_byte;

    assign req      = ~bus.CH_EMPTY;
    assign req8     = 8'(req);
    assign data_pad = 256'(bus.CH_DATA);
    assign full_w   = (cnt_q == DEPTH_C);

    // Pick the first non-empty channel at or after the pointer; nothing is
    // granted while the FIFO is full or the block is held in reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        if (RSTn && !full_w) begin
            for (int k = 0; k < CHANNELS; k++) begin
                rr_idx = {1'b0, ptr_q} + 4'(k);
                if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
                if (!gnt_vld && req8[rr_idx[2:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx[2:0];
                end
            end
        end
    end

    // Pointer moves past the granted channel; unchanged without a grant.
    always_comb begin
        nxt_idx = {1'b0, gnt_idx} + 4'd1;
        if (nxt_idx >= NCH) nxt_idx = '0;
        ptr_d = gnt_vld ? nxt_idx[2:0] : ptr_q;
    end

    assign gnt_oh      = 8'(gnt_vld) << gnt_idx;
    assign bus.CH_READ = gnt_oh[CHANNELS-1:0];
    assign wr_en       = gnt_vld;
    assign rd_word     = mem_q[rd_ptr_q];

    // FIFO storage: the granted word is captured in the same cycle as its read strobe.
    always_ff @(posedge BUS_CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= {gnt_idx, data_pad[{gnt_idx, 5'b0} +: 32]};
    end

    // Occupancy follows the simultaneous push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    end

    // Arbiter pointer, FIFO pointers, occupancy and accepted-word counter.
    always_ff @(posedge BUS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                wcnt_q   <= wcnt_q + 16'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign FIFO_FULL  = full_w;
    assign FIFO_EMPTY = (cnt_q == '0);
    assign WORD_CNT   = wcnt_q;

    // Serializer state register.
    always_ff @(posedge BUS_CLK or negedge RSTn) begin
        if (!RSTn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Serializer next state and byte select; backpressure freezes everything,
    // including the initial load from IDLE so a stalled link leaves words in the FIFO.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_wr   = 1'b0;
        tx_byte = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (!FIFO_EMPTY && !bus.TX_AFULL) begin
                    pop     = 1'b1;
                    state_d = FIRST_ST;
                end
            end
            S_HDR: begin
                tx_byte = {4'hA, 1'b0, ch_q};
                if (!bus.TX_AFULL) begin
                    tx_wr   = 1'b1;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                tx_byte = word_q[7:0];
                if (!bus.TX_AFULL) begin
                    tx_wr   = 1'b1;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                tx_byte = word_q[15:8];
                if (!bus.TX_AFULL) begin
                    tx_wr   = 1'b1;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                tx_byte = word_q[23:16];
                if (!bus.TX_AFULL) begin
                    tx_wr   = 1'b1;
                    state_d = S_B3;
                end
            end
            S_B3: begin
                tx_byte = word_q[31:24];
                if (!bus.TX_AFULL) begin
                    tx_wr = 1'b1;
                    if (!FIFO_EMPTY) begin
                        pop     = 1'b1;
                        state_d = FIRST_ST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register for the word being serialized.
    always_ff @(posedge BUS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            word_q <= '0;
            ch_q   <= '0;
        end else if (pop) begin
            ch_q   <= rd_word[34:32];
            word_q <= rd_word[31:0];
        end
    end

    assign bus.TX_WR   = tx_wr;
    assign bus.TX_DATA = tx_wr ? tx_byte : 8'h00;

endmodule

// File: tb/tb_tcp_stream_mux.sv
// Bench for tcp_stream_mux: two instances (2 channels without header,
// 4 channels with header, both DEPTH=4) fed by FWFT source models.
// Each granted word pushes its expected bytes to a per-instance queue;
// each TX_WR pops and compares.
module tb_tcp_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic full_a, empty_a, full_b, empty_b;
    logic [15:0] cnt_a, cnt_b;

    tcp_stream_mux_if #(.CHANNELS(2)) bus_a ();
    tcp_stream_mux_if #(.CHANNELS(4)) bus_b ();

    tcp_stream_mux #(.CHANNELS(2), .DEPTH(4), .HEADER_EN(1'b0)) u_a (
        .BUS_CLK(clk), .RSTn(rst_a_n), .bus(bus_a),
        .FIFO_FULL(full_a), .FIFO_EMPTY(empty_a), .WORD_CNT(cnt_a)
    );

    tcp_stream_mux #(.CHANNELS(4), .DEPTH(4), .HEADER_EN(1'b1)) u_b (
        .BUS_CLK(clk), .RSTn(rst_b_n), .bus(bus_b),
        .FIFO_FULL(full_b), .FIFO_EMPTY(empty_b), .WORD_CNT(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] src_a [2][64];
    logic [31:0] src_b [4][64];
    int hd_a [2], tl_a [2];
    int hd_b [4], tl_b [4];

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] cap_b [$];
    int         glog_b [$];

    logic [1:0] g_rd_a;
    logic [3:0] g_rd_b;
    logic       g_wr_a, g_wr_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            bus_a.CH_EMPTY[i]         = (hd_a[i] == tl_a[i]);
            bus_a.CH_DATA[32*i +: 32] = src_a[i][hd_a[i]];
        end
        for (int i = 0; i < 4; i++) begin
            bus_b.CH_EMPTY[i]         = (hd_b[i] == tl_b[i]);
            bus_b.CH_DATA[32*i +: 32] = src_b[i][hd_b[i]];
        end
    endtask

    task automatic add_a(input int ch, input logic [31:0] w);
        src_a[ch][tl_a[ch]] = w;
        tl_a[ch]++;
    endtask

    task automatic add_b(input int ch, input logic [31:0] w);
        src_b[ch][tl_b[ch]] = w;
        tl_b[ch]++;
    endtask

    function automatic int pend();
        int s = 0;
        for (int i = 0; i < 2; i++) s += tl_a[i] - hd_a[i];
        for (int i = 0; i < 4; i++) s += tl_b[i] - hd_b[i];
        return s;
    endfunction

    // One clock: sample at negedge, score, then advance sources after posedge.
    task automatic step();
        logic [1:0]  ra;
        logic [3:0]  rb;
        logic [31:0] w;
        @(negedge clk);
        ra = bus_a.CH_READ;
        rb = bus_b.CH_READ;
        g_rd_a = ra; g_rd_b = rb;
        g_wr_a = bus_a.TX_WR; g_wr_b = bus_b.TX_WR;
        chk("a_rd_legal", 32'($onehot0(ra) && ((ra & bus_a.CH_EMPTY) == 0) && !(full_a && ra != 0)), 1);
        chk("b_rd_legal", 32'($onehot0(rb) && ((rb & bus_b.CH_EMPTY) == 0) && !(full_b && rb != 0)), 1);
        for (int i = 0; i < 2; i++) if (ra[i]) begin
            w = src_a[i][hd_a[i]];
            exp_a.push_back(w[7:0]);   exp_a.push_back(w[15:8]);
            exp_a.push_back(w[23:16]); exp_a.push_back(w[31:24]);
        end
        for (int i = 0; i < 4; i++) if (rb[i]) begin
            w = src_b[i][hd_b[i]];
            glog_b.push_back(i);
            exp_b.push_back(8'hA0 | 8'(i));
            exp_b.push_back(w[7:0]);   exp_b.push_back(w[15:8]);
            exp_b.push_back(w[23:16]); exp_b.push_back(w[31:24]);
        end
        if (g_wr_a) begin
            if (exp_a.size() == 0) chk("a_tx_extra", bus_a.TX_DATA, 32'hFFFF_FFFF);
            else                   chk("a_tx_byte", bus_a.TX_DATA, exp_a.pop_front());
        end else chk("a_tx_idle", bus_a.TX_DATA, 0);
        if (g_wr_b) begin
            cap_b.push_back(bus_b.TX_DATA);
            if (exp_b.size() == 0) chk("b_tx_extra", bus_b.TX_DATA, 32'hFFFF_FFFF);
            else                   chk("b_tx_byte", bus_b.TX_DATA, exp_b.pop_front());
        end else chk("b_tx_idle", bus_b.TX_DATA, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (ra[i]) hd_a[i]++;
        for (int i = 0; i < 4; i++) if (rb[i]) hd_b[i]++;
        drive();
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || pend() != 0) && guard < 600) begin
            step();
            guard++;
        end
        chk(tag, exp_a.size() + exp_b.size() + pend(), 0);
        repeat (3) step();
    endtask

    task automatic chk_rst_a(input string tag);
        chk({tag, "_rd"},    bus_a.CH_READ, 0);
        chk({tag, "_wr"},    bus_a.TX_WR, 0);
        chk({tag, "_data"},  bus_a.TX_DATA, 0);
        chk({tag, "_full"},  full_a, 0);
        chk({tag, "_empty"}, empty_a, 1);
        chk({tag, "_cnt"},   cnt_a, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] e3 [5];
        int guard;
        e3 = '{8'hA3, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 2; i++) begin hd_a[i] = 0; tl_a[i] = 0; end
        for (int i = 0; i < 4; i++) begin hd_b[i] = 0; tl_b[i] = 0; end
        bus_a.CH_DATA = '0; bus_b.CH_DATA = '0;
        bus_a.TX_AFULL = 1'b0; bus_b.TX_AFULL = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk_rst_a("rst0_a");
        chk("rst0_b_rd", bus_b.CH_READ, 0);
        chk("rst0_b_wr", bus_b.TX_WR, 0);
        chk("rst0_b_empty", empty_b, 1);
        chk("rst0_b_full", full_b, 0);
        chk("rst0_b_cnt", cnt_b, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // single word, latency and byte order
        add_a(0, 32'h44332211); drive();
        step(); chk("t1_grant", g_rd_a, 2'b01);
        step(); chk("t1_lat1", g_wr_a, 0);
        step(); chk("t1_lat2", g_wr_a, 1);
        repeat (3) begin step(); chk("t1_stream", g_wr_a, 1); end
        step(); chk("t1_done", g_wr_a, 0);
        chk("t1_cnt", cnt_a, 1);

        // round robin with all four channels busy
        for (int w = 0; w < 8; w++)
            for (int c = 0; c < 4; c++) add_b(c, $urandom);
        drive();
        for (int c = 0; c < 5; c++) begin step(); chk("t2_onehot", $countones(g_rd_b), 1); end
        guard = 0;
        while (glog_b.size() < 32 && guard < 400) begin step(); guard++; end
        chk("t2_ngrant", glog_b.size(), 32);
        for (int k = 0; k < glog_b.size(); k++) chk("t2_order", glog_b[k], k % 4);
        drain("t2_drain");
        chk("t2_cnt", cnt_b, 32);

        // header byte on channel 3
        glog_b.delete(); cap_b.delete();
        add_b(3, 32'hDEADBEEF); drive();
        drain("t3_drain");
        chk("t3_nbytes", cap_b.size(), 5);
        for (int k = 0; k < 5 && k < cap_b.size(); k++) chk("t3_byte", cap_b[k], e3[k]);

        // backpressure mid-word
        add_a(1, 32'h87654321); drive();
        guard = 0;
        do begin step(); guard++; end while (!g_wr_a && guard < 10);
        chk("t4_start", g_wr_a, 1);
        step();
        bus_a.TX_AFULL = 1'b1;
        repeat (10) begin step(); chk("t4_hold", g_wr_a, 0); end
        bus_a.TX_AFULL = 1'b0;
        step(); chk("t4_resume", g_wr_a, 1);
        drain("t4_drain");

        // fill the 4-deep FIFO under backpressure
        rst_a_n = 1'b0; exp_a.delete(); step(); rst_a_n = 1'b1;
        bus_a.TX_AFULL = 1'b1;
        for (int w = 0; w < 3; w++) begin add_a(0, $urandom); add_a(1, $urandom); end
        drive();
        for (int c = 0; c < 4; c++) begin step(); chk("t5_grant", g_rd_a, (c % 2 == 0) ? 1 : 2); end
        step();
        chk("t5_full", full_a, 1);
        chk("t5_blocked", g_rd_a, 0);
        chk("t5_cnt", cnt_a, 4);
        repeat (3) begin step(); chk("t5_still_blocked", g_rd_a, 0); end
        bus_a.TX_AFULL = 1'b0;
        drain("t5_drain");
        chk("t5_cnt_end", cnt_a, 6);

        // reset during B1
        add_a(0, 32'hCAFEF00D); drive();
        guard = 0;
        do begin step(); guard++; end while (!g_wr_a && guard < 10);
        chk("t6_start", g_wr_a, 1);
        add_a(1, 32'h0BADBEEF); drive();
        rst_a_n = 1'b0;
        #1;
        chk_rst_a("t6_rst");
        exp_a.delete();
        step();
        rst_a_n = 1'b1;
        drain("t6_drain");
        chk("t6_cnt", cnt_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
